// File: rtl/rgb2hsv_pipe.sv
// rgb2hsv_pipe: four-stage streaming RGB to HSV converter with valid/ready flow control.
// Ports: clk, reset_n (async active-low); in_valid/in_ready/in_r/in_g/in_b/in_user accept a pixel;
//        out_valid/out_ready/out_h (degrees 0..359)/out_s/out_v/out_user deliver it 4 cycles later.
// Build macro RGB2HSV_THRESH_EN adds th_h_lo/th_h_hi/th_s_min/th_v_min inputs and an out_mask output.
module rgb2hsv_pipe #(
   parameter int COLOR_W = 8,
   parameter int USER_W  = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [COLOR_W-1:0] in_r,
   input  logic [COLOR_W-1:0] in_g,
   input  logic [COLOR_W-1:0] in_b,
   input  logic [USER_W-1:0]  in_user,
`ifdef RGB2HSV_THRESH_EN
   input  logic [8:0]         th_h_lo,
   input  logic [8:0]         th_h_hi,
   input  logic [COLOR_W-1:0] th_s_min,
   input  logic [COLOR_W-1:0] th_v_min,
   output logic               out_mask,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8:0]         out_h,
   output logic [COLOR_W-1:0] out_s,
   output logic [COLOR_W-1:0] out_v,
   output logic [USER_W-1:0]  out_user
);
   // 60 * (+/-(2^COLOR_W-1)) needs COLOR_W+6 magnitude bits plus sign
   localparam int NW = COLOR_W + 7;
   localparam logic signed [NW-1:0] SIXTY = NW'(60);
   logic en;
   logic v1_q, v2_q, v3_q;
   logic [COLOR_W-1:0] r1_q, g1_q, b1_q, max2_q, dlt2_q, max3_q, s3_q;
   logic [USER_W-1:0] u1_q, u2_q, u3_q;
   logic [1:0] dom2_q, dom3_q;
   logic signed [NW-1:0] num2_q;
   logic signed [7:0] hq3_q;
   logic [1:0] dom_d;
   logic [COLOR_W-1:0] max_d, min_d, hden_d, sden_d, s_d;
   logic signed [COLOR_W:0] dif_d;
   logic signed [NW-1:0] num_d;
   logic signed [7:0] hq_d;
   logic signed [9:0] hs_d;
   logic [8:0] h_d;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   // dom: 0=R, 1=G, 2=B; ties resolve toward R then G
   always_comb begin
      dom_d = (r1_q >= g1_q && r1_q >= b1_q) ? 2'd0 : (g1_q >= b1_q) ? 2'd1 : 2'd2;
      max_d = dom_d == 2'd0 ? r1_q : dom_d == 2'd1 ? g1_q : b1_q;
      min_d = (r1_q <= g1_q && r1_q <= b1_q) ? r1_q : (g1_q <= b1_q) ? g1_q : b1_q;
      dif_d = dom_d == 2'd0 ? $signed({1'b0, g1_q}) - $signed({1'b0, b1_q}) :
              dom_d == 2'd1 ? $signed({1'b0, b1_q}) - $signed({1'b0, r1_q}) :
                              $signed({1'b0, r1_q}) - $signed({1'b0, g1_q});
      num_d = NW'(dif_d) * SIXTY;
   end
   // |numerator| <= 60*delta, so the hue quotient fits in -60..60; zero divisors only occur with zero numerators
   always_comb begin
      hden_d = dlt2_q == '0 ? COLOR_W'(1) : dlt2_q;
      sden_d = max2_q == '0 ? COLOR_W'(1) : max2_q;
      hq_d   = 8'(num2_q / $signed(NW'(hden_d)));
      s_d    = COLOR_W'(({{COLOR_W{1'b0}}, dlt2_q} * {{COLOR_W{1'b0}}, {COLOR_W{1'b1}}}) /
                        {{COLOR_W{1'b0}}, sden_d});
   end
   // grey pixels land on dom=R with a zero numerator, giving hue 0 without a special case
   always_comb begin
      hs_d = (dom3_q == 2'd0 ? 10'sd0 : dom3_q == 2'd1 ? 10'sd120 : 10'sd240) + 10'(hq3_q);
      h_d  = hs_d < 0 ? 9'(hs_d + 10'sd360) : 9'(hs_d);
   end
`ifdef RGB2HSV_THRESH_EN
   logic mask_d;
   always_comb
      mask_d = s3_q >= th_s_min && max3_q >= th_v_min &&
               (th_h_lo <= th_h_hi ? (h_d >= th_h_lo && h_d <= th_h_hi) : (h_d >= th_h_lo || h_d <= th_h_hi));
`endif
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         {v1_q, v2_q, v3_q, out_valid} <= '0;
         {r1_q, g1_q, b1_q, u1_q} <= '0;
         {max2_q, dlt2_q, dom2_q, num2_q, u2_q} <= '0;
         {hq3_q, s3_q, max3_q, dom3_q, u3_q} <= '0;
         {out_h, out_s, out_v, out_user} <= '0;
`ifdef RGB2HSV_THRESH_EN
         out_mask <= 1'b0;
`endif
      end else if (en) begin
         {v1_q, r1_q, g1_q, b1_q, u1_q} <= {in_valid, in_r, in_g, in_b, in_user};
         {v2_q, max2_q, dlt2_q, dom2_q, num2_q, u2_q} <= {v1_q, max_d, max_d - min_d, dom_d, num_d, u1_q};
         {v3_q, hq3_q, s3_q, max3_q, dom3_q, u3_q} <= {v2_q, hq_d, s_d, max2_q, dom2_q, u2_q};
         {out_valid, out_h, out_s, out_v, out_user} <= {v3_q, h_d, s3_q, max3_q, u3_q};
`ifdef RGB2HSV_THRESH_EN
         out_mask <= mask_d;
`endif
      end
endmodule
